segre_dcache_refill_unit: RTL and testbench

Memory-side responder for the data-cache miss interface driven by the TL stage. It accepts a line-miss request, writes back the dirty victim line if needed, and fetches the missing line from main memory. It then returns the line with its aligned address and the victim index to fill. It also owns the data-cache replacement state (true LRU via age counters), which is updated on every hit and fill.

---
 rtl/segre_dcache_refill_unit_pkg.sv | 13 +
 rtl/segre_dcache_refill_unit_if.sv | 16 +
 rtl/segre_dcache_refill_unit_lru_ages.sv | 26 ++
 rtl/segre_dcache_refill_unit.sv | 87 ++++++++
 tb/tb_segre_dcache_refill_unit.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/segre_dcache_refill_unit_pkg.sv
// segre_dcache_refill_unit_pkg: shared types and default sizes for the dcache refill unit
package segre_dcache_refill_unit_pkg;
  localparam int DCACHE_ADDR_SIZE = 32;
  localparam int DCACHE_LANE_SIZE = 128;
  localparam int DCACHE_INDEX_SIZE = 2;
  localparam int DCACHE_BYTE_SIZE = 4;
  typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ, RESP} refill_fsm_state_e;
  typedef struct packed {
    logic we;
    logic [DCACHE_ADDR_SIZE-1:0] addr;
    logic [DCACHE_LANE_SIZE-1:0] wdata;
  } refill_req_t;
endpackage

// File: rtl/segre_dcache_refill_unit_if.sv
// segre_dcache_refill_unit_if: line-granular memory request/grant bus
interface segre_dcache_refill_unit_if
  import segre_dcache_refill_unit_pkg::*;
#(
  parameter int ADDR_SIZE = DCACHE_ADDR_SIZE,
  parameter int LANE_SIZE = DCACHE_LANE_SIZE
);
  logic mem_req_o;
  logic mem_we_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [LANE_SIZE-1:0] mem_wdata_o;
  logic mem_gnt_i;
  logic [LANE_SIZE-1:0] mem_rdata_i;
  modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, input mem_gnt_i, mem_rdata_i);
  modport slave (input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, output mem_gnt_i, mem_rdata_i);
endinterface

// File: rtl/segre_dcache_refill_unit_lru_ages.sv
// segre_lru_ages: true-LRU replacement state kept as a permutation of age counters
module segre_lru_ages
  import segre_dcache_refill_unit_pkg::*;
#(
  parameter int INDEX_SIZE = DCACHE_INDEX_SIZE
) (
  input  logic clk_i,
  input  logic rsn_i,
  input  logic touch_valid,
  input  logic [INDEX_SIZE-1:0] touch_index,
  output logic [INDEX_SIZE-1:0] victim_index
);
  localparam int NUM_LINES = 2**INDEX_SIZE;
  logic [INDEX_SIZE-1:0] age [NUM_LINES];
  always_comb begin
    victim_index = '0;
    for (int k = 0; k < NUM_LINES; k++)
      if (age[k] == INDEX_SIZE'(NUM_LINES-1)) victim_index = INDEX_SIZE'(k);
  end
  always_ff @(posedge clk_i)
    for (int k = 0; k < NUM_LINES; k++)
      if (!rsn_i) age[k] <= INDEX_SIZE'(k);
      else if (touch_valid)
        age[k] <= INDEX_SIZE'(k) == touch_index ? '0 :
                  age[k] < age[touch_index] ? age[k] + 1'b1 : age[k];
endmodule

// File: rtl/segre_dcache_refill_unit.sv
// segre_dcache_refill_unit: services dcache line misses with optional victim writeback, owns LRU state
module segre_dcache_refill_unit
  import segre_dcache_refill_unit_pkg::*;
#(
  parameter int ADDR_SIZE = DCACHE_ADDR_SIZE,
  parameter int LANE_SIZE = DCACHE_LANE_SIZE,
  parameter int INDEX_SIZE = DCACHE_INDEX_SIZE,
  parameter int BYTE_SIZE = DCACHE_BYTE_SIZE
) (
  input  logic clk_i,
  input  logic rsn_i,
  input  logic tl_miss_i,
  input  logic [ADDR_SIZE-1:0] tl_addr_i,
  input  logic hit_valid_i,
  input  logic [INDEX_SIZE-1:0] hit_index_i,
  input  logic victim_dirty_i,
  input  logic [ADDR_SIZE-1:0] victim_addr_i,
  input  logic [LANE_SIZE-1:0] victim_data_i,
  output logic data_rdy_o,
  output logic [LANE_SIZE-1:0] data_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [INDEX_SIZE-1:0] lru_index_o,
  output logic busy_o,
  segre_dcache_refill_unit_if.master mem
);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = {ADDR_SIZE{1'b1}} << BYTE_SIZE;
  refill_fsm_state_e state;
  refill_req_t req;
  logic req_valid;
  logic [ADDR_SIZE-1:0] miss_addr;
  logic [INDEX_SIZE-1:0] fill_idx, victim_index;
  assign mem.mem_req_o = req_valid;
  assign mem.mem_we_o = req.we;
  assign mem.mem_addr_o = req.addr;
  assign mem.mem_wdata_o = req.wdata;
  assign busy_o = state != IDLE;
  assign lru_index_o = busy_o ? fill_idx : victim_index;
  // the fill touch in RESP takes priority over any concurrent hit
  segre_lru_ages #(.INDEX_SIZE(INDEX_SIZE)) u_lru_ages (
    .clk_i,
    .rsn_i,
    .touch_valid(hit_valid_i || state == RESP),
    .touch_index(state == RESP ? fill_idx : hit_index_i),
    .victim_index
  );
  always_ff @(posedge clk_i)
    if (!rsn_i) begin
      state <= IDLE;
      req_valid <= 1'b0;
      req <= '0;
      data_rdy_o <= 1'b0;
      data_o <= '0;
      addr_o <= '0;
      miss_addr <= '0;
      fill_idx <= '0;
    end else
      case (state)
        IDLE:
          if (tl_miss_i) begin
            miss_addr <= tl_addr_i & LINE_MASK;
            fill_idx <= victim_index;
            req_valid <= 1'b1;
            req.we <= victim_dirty_i;
            req.addr <= victim_dirty_i ? victim_addr_i : tl_addr_i & LINE_MASK;
            req.wdata <= victim_data_i;
            state <= victim_dirty_i ? WB_REQ : RD_REQ;
          end
        WB_REQ:
          if (mem.mem_gnt_i) begin
            req.we <= 1'b0;
            req.addr <= miss_addr;
            state <= RD_REQ;
          end
        RD_REQ:
          if (mem.mem_gnt_i) begin
            req_valid <= 1'b0;
            data_o <= mem.mem_rdata_i;
            addr_o <= miss_addr;
            data_rdy_o <= 1'b1;
            state <= RESP;
          end
        default: begin
          data_rdy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_segre_dcache_refill_unit.sv
// tb_segre_dcache_refill_unit: directed and randomized checks against a recency-list LRU model
module tb_segre_dcache_refill_unit;
  logic clk = 0, rsn = 0, tl_miss = 0, hit_valid = 0, victim_dirty = 0;
  logic data_rdy, busy;
  logic [31:0] tl_addr = 0, victim_addr = 0, addr_o;
  logic [1:0] hit_index = 0, lru_index;
  logic [127:0] victim_data = 0, data_o;
  int checks = 0, errors = 0;
  int q[$];
  segre_dcache_refill_unit_if mem_if ();
  segre_dcache_refill_unit dut (
    .clk_i(clk), .rsn_i(rsn), .tl_miss_i(tl_miss), .tl_addr_i(tl_addr),
    .hit_valid_i(hit_valid), .hit_index_i(hit_index), .victim_dirty_i(victim_dirty),
    .victim_addr_i(victim_addr), .victim_data_i(victim_data), .data_rdy_o(data_rdy),
    .data_o(data_o), .addr_o(addr_o), .lru_index_o(lru_index), .busy_o(busy), .mem(mem_if.master)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // recency list: front is most recently used, back is the victim
  function automatic void touch(int i);
    for (int k = 0; k < q.size(); k++)
      if (q[k] == i) begin
        q.delete(k);
        break;
      end
    q.push_front(i);
  endfunction
  function automatic void model_reset;
    q = {0, 1, 2, 3};
  endfunction
  task automatic hit(input int i);
    hit_valid = 1;
    hit_index = 2'(i);
    tick;
    hit_valid = 0;
    touch(i);
  endtask
  task automatic do_reset;
    rsn = 0;
    tick;
    model_reset();
    rsn = 1;
    tick;
  endtask
  task automatic miss(input logic [31:0] a, input bit dirty, input logic [31:0] va, input logic [127:0] vd,
                      input logic [127:0] rd, input int wbw, input int rdw, input bit hold,
                      input int mid_hit, input int resp_hit);
    int fill;
    logic [31:0] la;
    fill = q[$];
    la = a & 32'hFFFF_FFF0;
    chk("idle_victim", lru_index, fill);
    tl_miss = 1; tl_addr = a; victim_dirty = dirty; victim_addr = va; victim_data = vd;
    tick;
    if (!hold) tl_miss = 0;
    victim_dirty = 1'($urandom); victim_addr = $urandom; victim_data = {4{$urandom}};
    if (dirty) begin
      for (int i = 0; i <= wbw; i++) begin
        chk("wb_req", mem_if.mem_req_o, 1);
        chk("wb_we", mem_if.mem_we_o, 1);
        chk("wb_addr", mem_if.mem_addr_o, va);
        chk("wb_wdata", mem_if.mem_wdata_o, vd);
        chk("wb_rdy", data_rdy, 0);
        chk("wb_lru", lru_index, fill);
        if (i == wbw) mem_if.mem_gnt_i = 1;
        tick;
      end
      mem_if.mem_gnt_i = 0;
    end
    for (int i = 0; i <= rdw; i++) begin
      chk("rd_req", mem_if.mem_req_o, 1);
      chk("rd_we", mem_if.mem_we_o, 0);
      chk("rd_addr", mem_if.mem_addr_o, la);
      chk("rd_rdy", data_rdy, 0);
      chk("rd_busy", busy, 1);
      chk("rd_lru", lru_index, fill);
      if (i == 0 && mid_hit >= 0) begin
        hit_valid = 1;
        hit_index = 2'(mid_hit);
        touch(mid_hit);
      end
      if (i == rdw) begin
        mem_if.mem_gnt_i = 1;
        mem_if.mem_rdata_i = rd;
      end
      tick;
      hit_valid = 0;
    end
    mem_if.mem_gnt_i = 0;
    mem_if.mem_rdata_i = {4{$urandom}};
    chk("resp_rdy", data_rdy, 1);
    chk("resp_data", data_o, rd);
    chk("resp_addr", addr_o, la);
    chk("resp_lru", lru_index, fill);
    chk("resp_req", mem_if.mem_req_o, 0);
    chk("resp_busy", busy, 1);
    if (resp_hit >= 0) begin
      hit_valid = 1;
      hit_index = 2'(resp_hit);
    end
    touch(fill);
    tick;
    hit_valid = 0;
    chk("post_rdy", data_rdy, 0);
    chk("post_busy", busy, 0);
    chk("post_victim", lru_index, q[$]);
  endtask
  initial begin
    mem_if.mem_gnt_i = 0;
    mem_if.mem_rdata_i = 0;
    tick;
    tick;
    chk("rst_req", mem_if.mem_req_o, 0);
    chk("rst_we", mem_if.mem_we_o, 0);
    chk("rst_addr", mem_if.mem_addr_o, 0);
    chk("rst_wdata", mem_if.mem_wdata_o, 0);
    chk("rst_rdy", data_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr_o", addr_o, 0);
    chk("rst_lru", lru_index, 3);
    model_reset();
    rsn = 1;
    tick;
    miss(32'h0000_1234, 0, 0, 0, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 0, 4, 0, -1, -1);
    miss(32'h0000_4567, 1, 32'h0000_8000, {16{8'hA5}}, {4{$urandom}}, 2, 1, 0, -1, -1);
    do_reset();
    hit(3);
    hit(0);
    hit(1);
    chk("lru_after_hits", lru_index, 2);
    miss(32'h0000_0040, 0, 0, 0, {4{$urandom}}, 0, 0, 0, -1, -1);
    chk("next_victim", lru_index, 3);
    miss(32'h0000_2008, 0, 0, 0, {4{$urandom}}, 0, 2, 1, q[$], -1);
    chk("held_miss_idle", busy, 0);
    miss(32'h0000_200C, 0, 0, 0, {4{$urandom}}, 0, 1, 0, -1, -1);
    tl_miss = 1; tl_addr = 32'h0000_3000; victim_dirty = 0;
    tick;
    tl_miss = 0;
    tick;
    tick;
    chk("pre_rst_req", mem_if.mem_req_o, 1);
    rsn = 0;
    tick;
    model_reset();
    chk("midrst_req", mem_if.mem_req_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", data_rdy, 0);
    chk("midrst_lru", lru_index, 3);
    rsn = 1;
    tick;
    hit(3);
    hit(2);
    miss(32'h0000_5550, 0, 0, 0, {4{$urandom}}, 0, 1, 0, -1, 0);
    chk("resp_hit_dropped", lru_index, 0);
    for (int n = 0; n < 20; n++) begin
      for (int h = $urandom_range(0, 2); h > 0; h--) hit(int'($urandom_range(0, 3)));
      miss($urandom, 1'($urandom), $urandom & 32'hFFFF_FFF0, {4{$urandom}}, {4{$urandom}},
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0,
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : -1,
           ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
